// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared constants and the fetch queue entry type
// Rev 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : in-order slot buffer, allocated on request, filled on response
// Rev 1.0
// ============================================================================
module fetch_queue
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    fetch_entry_t  r_slot [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign count      = r_count;
    assign head_pc    = r_slot[r_rd_ptr].pc;
    assign head_instr = r_slot[r_rd_ptr].instr;
    assign head_valid = (r_count != '0) && r_slot[r_rd_ptr].filled;
    assign w_pop      = pop && head_valid;

    // Issue gating guarantees the alloc, fill and pop slots never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                r_slot[r_wr_ptr].pc     <= alloc_pc;
                r_slot[r_wr_ptr].filled <= 1'b0;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (fill) begin
                r_slot[r_fill_ptr].instr  <= fill_data;
                r_slot[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr                <= r_fill_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(alloc) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC, request issue, redirect flush and stale-response dropping
// Rev 1.0    : FETCH_MISALIGN_CHECK_EN adds out_misalign and a halt on bad target
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            out_misalign
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_pend;
    logic [CW-1:0]   w_count;
    logic            w_accept;
    logic            w_fill;
    logic            w_drop_rsp;
    logic            w_head_valid;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_show;
    logic            w_halt;

    assign w_accept   = imem_req_valid && imem_req_ready;
    assign w_drop_rsp = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_fill     = imem_rsp_valid && (r_drop_cnt == '0);

    // count covers live requests and buffered words; drop_cnt covers stale requests.
    assign imem_req_valid = rst_n && !redirect_valid && !w_halt &&
                            ((w_count + r_drop_cnt) < CW'(DEPTH));
    assign imem_req_addr  = r_pc;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .alloc      (w_accept),
        .alloc_pc   (r_pc),
        .fill       (w_fill),
        .fill_data  (imem_rsp_data),
        .pop        (out_ready),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head_pc    (w_head_pc),
        .head_instr (w_head_instr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
            r_pend     <= '0;
        end else begin
            r_pend <= r_pend + CW'(w_accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc       <= w_redirect_pc;
                r_drop_cnt <= r_pend - CW'(imem_rsp_valid);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop_rsp) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    // A misaligned target keeps its low bits in r_pc so the NOP entry reports it.
    assign w_redirect_pc = redirect_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = (redirect_pc[1:0] != 2'b00) ? ST_SHOW : ST_RUN;
        end else if ((r_state == ST_SHOW) && out_ready) begin
            w_state_next = ST_HALT;
        end
    end

    always_comb begin
        w_show = (r_state == ST_SHOW);
        w_halt = (r_state != ST_RUN);
    end

    assign out_misalign = w_show;
`else
    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_show        = 1'b0;
    assign w_halt        = 1'b0;
`endif

    assign out_valid = w_show || w_head_valid;
    assign out_instr = w_show ? NOP_INSTR : w_head_instr;
    assign out_pc    = w_show ? r_pc : w_head_pc;

endmodule
`default_nettype wire
